// File: rtl/tron_pkg.sv
// Shared types for the Tron match sequencer: game state encoding and winner codes.
package tron_pkg;

  typedef enum logic [2:0] {
    TITLE      = 3'd0,
    COUNTDOWN  = 3'd1,
    PLAY       = 3'd2,
    ROUND_END  = 3'd3,
    MATCH_OVER = 3'd4,
    PAUSED     = 3'd7
  } game_state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_BLUE = 2'b01;
  localparam logic [1:0] WIN_RED  = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/game_ctrl_sync_edge.sv
// Two-flop synchronizer for an asynchronous level, followed by a one-Clk rising-edge pulse.
module sync_edge (
  input  logic Clk,
  input  logic Reset_n,
  input  logic d_async,
  output logic rise_pulse
);

  logic s1, s2, s3;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d_async;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise_pulse = s2 & ~s3;

endmodule

// File: rtl/game_ctrl.sv
// Tron match sequencer: title, countdown, play, crash hold, match-over.
// Optional pause feature is compiled in with GAME_PAUSE_EN.
module game_ctrl
  import tron_pkg::*;
#(
  parameter int FRAMES_PER_SEC = 60,
  parameter int COUNT_SECS     = 3,
  parameter int HOLD_FRAMES    = 90
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       start_key,
  input  logic       pause_key,
  input  logic       reset_round,
  input  logic       Blue_W,
  input  logic       Red_W,
  output logic [2:0] Game_State,
  output logic       round_reset,
  output logic       bikes_enable,
  output logic [1:0] countdown,
  output logic [1:0] winner
);

  localparam int FCW = $clog2(max_int(FRAMES_PER_SEC, HOLD_FRAMES) + 1);
  localparam logic [FCW-1:0] FPS_LAST   = FCW'(FRAMES_PER_SEC - 1);
  localparam logic [FCW-1:0] HOLD_LAST  = FCW'(HOLD_FRAMES - 1);
  localparam logic [1:0]     COUNT_STEP = 2'(COUNT_SECS);

  logic frame_edge, start_edge, pause_edge;

  sync_edge u_frame (.Clk(Clk), .Reset_n(Reset_n), .d_async(frame_clk), .rise_pulse(frame_edge));
  sync_edge u_start (.Clk(Clk), .Reset_n(Reset_n), .d_async(start_key), .rise_pulse(start_edge));
  sync_edge u_pause (.Clk(Clk), .Reset_n(Reset_n), .d_async(pause_key), .rise_pulse(pause_edge));

`ifndef GAME_PAUSE_EN
  logic unused_pause;
  assign unused_pause = pause_edge;
`endif

  game_state_t    state;
  logic [FCW-1:0] fcnt;
  logic [1:0]     step;
  logic           blue_l, red_l;
  logic [1:0]     winner_q;
  logic           bikes_q;
  logic           round_reset_q;
  logic           crash;

  assign crash = reset_round | Blue_W | Red_W;

  // The win pulse trails reset_round by a cycle, so both latches keep
  // collecting through ROUND_END and the decision also sees this cycle's pulses.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state         <= TITLE;
      fcnt          <= '0;
      step          <= 2'd0;
      blue_l        <= 1'b0;
      red_l         <= 1'b0;
      winner_q      <= WIN_NONE;
      bikes_q       <= 1'b0;
      round_reset_q <= 1'b0;
    end else begin
      round_reset_q <= 1'b0;
      case (state)
        TITLE: begin
          blue_l <= 1'b0;
          red_l  <= 1'b0;
          if (start_edge) begin
            state         <= COUNTDOWN;
            step          <= COUNT_STEP;
            fcnt          <= '0;
            round_reset_q <= 1'b1;
          end
        end
        COUNTDOWN: begin
          if (frame_edge) begin
            if (fcnt == FPS_LAST) begin
              fcnt <= '0;
              step <= step - 2'd1;
              if (step == 2'd1) begin
                state   <= PLAY;
                bikes_q <= 1'b1;
              end
            end else begin
              fcnt <= fcnt + 1'b1;
            end
          end
        end
        PLAY: begin
          blue_l <= blue_l | Blue_W;
          red_l  <= red_l | Red_W;
          if (crash) begin
            state   <= ROUND_END;
            fcnt    <= '0;
            bikes_q <= 1'b0;
          end
`ifdef GAME_PAUSE_EN
          else if (pause_edge) begin
            state   <= PAUSED;
            bikes_q <= 1'b0;
          end
`endif
        end
        ROUND_END: begin
          blue_l <= blue_l | Blue_W;
          red_l  <= red_l | Red_W;
          if (frame_edge) begin
            if (fcnt == HOLD_LAST) begin
              fcnt <= '0;
              if (blue_l | red_l | Blue_W | Red_W) begin
                state    <= MATCH_OVER;
                winner_q <= {red_l | Red_W, blue_l | Blue_W};
              end else begin
                state         <= COUNTDOWN;
                step          <= COUNT_STEP;
                round_reset_q <= 1'b1;
              end
            end else begin
              fcnt <= fcnt + 1'b1;
            end
          end
        end
        MATCH_OVER: begin
          if (start_edge) begin
            state    <= TITLE;
            winner_q <= WIN_NONE;
          end
        end
`ifdef GAME_PAUSE_EN
        PAUSED: begin
          blue_l <= blue_l | Blue_W;
          red_l  <= red_l | Red_W;
          if (crash) begin
            state <= ROUND_END;
            fcnt  <= '0;
          end else if (pause_edge) begin
            state   <= PLAY;
            bikes_q <= 1'b1;
          end
        end
`endif
        default: begin
          state    <= TITLE;
          fcnt     <= '0;
          step     <= 2'd0;
          blue_l   <= 1'b0;
          red_l    <= 1'b0;
          winner_q <= WIN_NONE;
          bikes_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Game_State   = state;
  assign round_reset  = round_reset_q;
  assign bikes_enable = bikes_q;
  assign countdown    = step;
  assign winner       = winner_q;

endmodule
